eth_tx_sched: RTL and testbench

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

---
 rtl/eth_tx_sched_pkg.sv | 16 +
 rtl/eth_tx_sched.sv | 169 ++++++++++++++++
 tb/tb_eth_tx_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_sched_pkg.sv
// rtl/eth_tx_sched_pkg.sv - shared state encoding and Ethernet/IP/UDP header constants
package eth_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARP_TX = 2'd1,
    UDP_TX = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
  localparam logic [15:0] IP_UDP_HDR_LEN = 16'd28;

endpackage

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin ARP/UDP frame scheduler feeding the datagram chain
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int ARP_PAD_LEN = 18,
  parameter int IFG_CYCLES  = 12,
  parameter int MAX_UDP_LEN = 1472
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic        arp_req,
  output logic        arp_ack,
  input  logic        udp_req,
  input  logic [15:0] udp_len,
  output logic        udp_ack,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        arp_enable,
  output logic        ip_enable,
  output logic        udp_enable,
  output logic [15:0] eth_type,
  output logic [15:0] IP_TotLen,
  output logic [15:0] UDP_TotLen,
  output logic        busy,
  output logic        len_err
);

  localparam logic [15:0] ARP_LAST = 16'(ARP_PAD_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_UDP_LEN);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] frame_len;
  logic        pad;
  logic        rr_arp;

  logic beat_hs;
  logic arp_last;
  logic udp_last;
  logic frame_end;
  logic len_ok;

  assign beat_hs   = m_axis_tvalid && m_axis_tready;
  assign arp_last  = (cnt == ARP_LAST);
  assign udp_last  = (cnt == frame_len - 16'd1);
  assign frame_end = beat_hs && (((state == ARP_TX) && arp_last) ||
                                 ((state == UDP_TX) && udp_last));
  assign len_ok    = (udp_len != 16'd0) && (udp_len <= MAX_LEN);
  assign busy      = (state != IDLE);

  always_comb begin
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      ARP_TX: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = arp_last;
        m_axis_tuser  = (cnt == 16'd0);
      end
      UDP_TX: begin
        m_axis_tlast = udp_last;
        m_axis_tuser = (cnt == 16'd0);
        // After an early tlast the source is cut off and zeros fill the frame
        if (pad) begin
          m_axis_tvalid = 1'b1;
        end else begin
          m_axis_tdata  = s_axis_tdata;
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      frame_len  <= 16'd0;
      pad        <= 1'b0;
      rr_arp     <= 1'b1;
      arp_ack    <= 1'b0;
      udp_ack    <= 1'b0;
      len_err    <= 1'b0;
      arp_enable <= 1'b0;
      ip_enable  <= 1'b0;
      udp_enable <= 1'b0;
      eth_type   <= 16'd0;
      IP_TotLen  <= 16'd0;
      UDP_TotLen <= 16'd0;
    end else begin
      arp_ack <= 1'b0;
      udp_ack <= 1'b0;
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          // A visible ack means the requester has not yet dropped its request
          if (!arp_ack && !udp_ack) begin
            if (arp_req && (!udp_req || rr_arp)) begin
              arp_ack    <= 1'b1;
              rr_arp     <= 1'b0;
              arp_enable <= 1'b1;
              ip_enable  <= 1'b0;
              udp_enable <= 1'b0;
              eth_type   <= ETH_TYPE_ARP;
              cnt        <= 16'd0;
              state      <= ARP_TX;
            end else if (udp_req) begin
              udp_ack <= 1'b1;
              rr_arp  <= 1'b1;
              if (len_ok) begin
                arp_enable <= 1'b0;
                ip_enable  <= 1'b1;
                udp_enable <= 1'b1;
                eth_type   <= ETH_TYPE_IPV4;
                UDP_TotLen <= udp_len + UDP_HDR_LEN;
                IP_TotLen  <= udp_len + IP_UDP_HDR_LEN;
                frame_len  <= udp_len;
                cnt        <= 16'd0;
                pad        <= 1'b0;
                state      <= UDP_TX;
              end else begin
                len_err <= 1'b1;
              end
            end
          end
        end
        ARP_TX: begin
          if (beat_hs) cnt <= cnt + 16'd1;
        end
        UDP_TX: begin
          if (beat_hs) begin
            cnt <= cnt + 16'd1;
            if (!pad && (s_axis_tlast != udp_last)) len_err <= 1'b1;
            if (!pad && s_axis_tlast && !udp_last) pad <= 1'b1;
          end
        end
        GAP: begin
          if (cnt == IFG_LAST) begin
            cnt   <= 16'd0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (frame_end) begin
        cnt <= 16'd0;
        pad <= 1'b0;
        if (IFG_CYCLES == 0) state <= IDLE;
        else state <= GAP;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - scoreboard bench for the ARP/UDP frame scheduler
module tb_eth_tx_sched;

  localparam int ARP_PAD_LEN = 18;
  localparam int IFG_CYCLES  = 12;
  localparam int MAX_UDP_LEN = 1472;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        arp_req = 1'b0, udp_req = 1'b0;
  logic [15:0] udp_len = 16'd0;
  logic        arp_ack, udp_ack;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        m_axis_tready;
  logic        arp_enable, ip_enable, udp_enable;
  logic [15:0] eth_type, IP_TotLen, UDP_TotLen;
  logic        busy, len_err;

  always #5 clk = ~clk;

  eth_tx_sched #(
    .ARP_PAD_LEN(ARP_PAD_LEN), .IFG_CYCLES(IFG_CYCLES), .MAX_UDP_LEN(MAX_UDP_LEN)
  ) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .arp_req(arp_req), .arp_ack(arp_ack),
    .udp_req(udp_req), .udp_len(udp_len), .udp_ack(udp_ack),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .arp_enable(arp_enable), .ip_enable(ip_enable), .udp_enable(udp_enable),
    .eth_type(eth_type), .IP_TotLen(IP_TotLen), .UDP_TotLen(UDP_TotLen),
    .busy(busy), .len_err(len_err)
  );

  typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;
  typedef struct packed {logic [7:0] data; logic last;} src_t;

  beat_t exp_q[$];
  src_t  src_q[$];
  int    n_chk = 0, n_pass = 0, len_err_cnt = 0;
  bit    rdy_rand = 1'b0, src_rand = 1'b0, rr_arp = 1'b1, src_hs;
  logic        exp_arp_en = 1'b0, exp_ip_en = 1'b0, exp_udp_en = 1'b0;
  logic [15:0] exp_eth = 16'd0, exp_ip = 16'd0, exp_udp = 16'd0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void fail(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Output monitor: every presented beat must match the head of the expected queue
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (len_err) len_err_cnt++;
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) chk("unexpected_beat", m_axis_tvalid, 1'b0);
        else begin
          chk(m_axis_tready ? "beat" : "stalled_beat",
              {m_axis_tdata, m_axis_tlast, m_axis_tuser}, exp_q[0]);
          if (m_axis_tready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Payload source: holds each byte until accepted, optional random bubbles
  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      src_hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() == 0) s_axis_tvalid = 1'b0;
      else if (!s_axis_tvalid || src_hs) begin
        s_axis_tdata  = src_q[0].data;
        s_axis_tlast  = src_q[0].last;
        s_axis_tvalid = (!src_rand || $urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    arp_req = 1'b0; udp_req = 1'b0;
    exp_q.delete(); src_q.delete();
    s_axis_tvalid = 1'b0;
    #1;
    chk("rst_stream", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready}, 4'b0);
    chk("rst_ctrl", {arp_ack, udp_ack, len_err, busy}, 4'b0);
    chk("rst_config", {arp_enable, ip_enable, udp_enable, eth_type, IP_TotLen, UDP_TotLen}, 51'd0);
    rr_arp = 1'b1;
    exp_arp_en = 1'b0; exp_ip_en = 1'b0; exp_udp_en = 1'b0;
    exp_eth = 16'd0; exp_ip = 16'd0; exp_udp = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0: tlast on final byte; 1: tlast on byte k (early); 2: no tlast at all
  task automatic prep_udp(input logic [15:0] len, input int mode, input int k,
                          input bit seq, output int exp_err);
    int sent;
    logic [7:0] b;
    sent = (mode == 1) ? k : int'(len);
    exp_err = (mode != 0) ? 1 : 0;
    for (int i = 0; i < int'(len); i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      if (i < sent)
        src_q.push_back({b, (mode == 0 && i == int'(len) - 1) || (mode == 1 && i == k - 1)});
      exp_q.push_back({(i < sent) ? b : 8'h00, i == int'(len) - 1, i == 0});
    end
    exp_arp_en = 1'b0; exp_ip_en = 1'b1; exp_udp_en = 1'b1;
    exp_eth = 16'h0800; exp_udp = len + 16'd8; exp_ip = len + 16'd28;
  endtask

  task automatic wait_ack(output bit ga, output bit gu);
    bit seen;
    ga = 1'b0; gu = 1'b0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (arp_ack || udp_ack) begin ga = arp_ack; gu = udp_ack; seen = 1'b1; end
    end
    if (!seen) fail("ack_wait");
  endtask

  task automatic wait_frame(input int bound);
    int i, g;
    i = 0; g = 0;
    while (exp_q.size() != 0 && i < bound) begin @(posedge clk); i++; end
    if (exp_q.size() != 0) begin fail("frame_wait"); exp_q.delete(); src_q.delete(); end
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (!busy) break;
      g++;
    end
    chk("gap_cycles", g, IFG_CYCLES);
  endtask

  task automatic txn(input bit a, input bit u, input logic [15:0] len,
                     input int mode, input int k, input bit seq);
    bit pa, pu, pick, bad, ga, gu;
    int e0, exp_err;
    pa = a; pu = u;
    @(posedge clk); #1;
    arp_req = a; udp_req = u; udp_len = len;
    while (pa || pu) begin
      pick = pa && (!pu || rr_arp);
      bad  = !pick && (len == 16'd0 || int'(len) > MAX_UDP_LEN);
      e0 = len_err_cnt; exp_err = 0;
      if (pick) begin
        for (int i = 0; i < ARP_PAD_LEN; i++)
          exp_q.push_back({8'h00, i == ARP_PAD_LEN - 1, i == 0});
        exp_arp_en = 1'b1; exp_ip_en = 1'b0; exp_udp_en = 1'b0; exp_eth = 16'h0806;
      end else if (!bad) prep_udp(len, mode, k, seq, exp_err);
      wait_ack(ga, gu);
      chk("arp_ack", ga, pick);
      chk("udp_ack", gu, !pick);
      chk("len_err_at_ack", len_err, bad);
      chk("busy_at_ack", busy, !bad);
      chk("config", {arp_enable, ip_enable, udp_enable, eth_type, IP_TotLen, UDP_TotLen},
          {exp_arp_en, exp_ip_en, exp_udp_en, exp_eth, exp_ip, exp_udp});
      @(posedge clk); #1;
      if (pick) begin arp_req = 1'b0; pa = 1'b0; end
      else begin udp_req = 1'b0; pu = 1'b0; end
      rr_arp = !pick;
      if (bad) begin
        @(negedge clk);
        chk("busy_after_reject", busy, 1'b0);
      end else begin
        wait_frame((pick ? ARP_PAD_LEN : int'(len)) * 8 + 200);
        chk("len_err_count", len_err_cnt - e0, exp_err);
      end
    end
  endtask

  initial begin
    bit ga, gu;
    int e, kind;
    logic [15:0] l;
    #2 do_reset();

    txn(1'b1, 1'b0, 16'd0, 0, 0, 1'b0);
    txn(1'b0, 1'b1, 16'd10, 0, 0, 1'b1);
    do_reset();
    txn(1'b1, 1'b1, 16'd10, 0, 0, 1'b1);
    txn(1'b1, 1'b1, 16'd6, 0, 0, 1'b0);
    txn(1'b0, 1'b1, 16'd1473, 0, 0, 1'b0);
    txn(1'b0, 1'b1, 16'd0, 0, 0, 1'b0);
    rdy_rand = 1'b1;
    txn(1'b0, 1'b1, 16'd8, 1, 5, 1'b1);
    txn(1'b0, 1'b1, 16'd9, 2, 0, 1'b1);
    src_rand = 1'b1;
    txn(1'b0, 1'b1, 16'(MAX_UDP_LEN), 0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 6);
      l = 16'($urandom_range(1, 40));
      case (kind)
        0:       txn(1'b1, 1'b0, l, 0, 0, 1'b0);
        1, 2:    txn(1'b0, 1'b1, l, 0, 0, 1'b0);
        3: begin
          if (l < 16'd2) l = 16'd2;
          txn(1'b0, 1'b1, l, 1, $urandom_range(1, int'(l) - 1), 1'b0);
        end
        4:       txn(1'b0, 1'b1, l, 2, 0, 1'b0);
        5:       txn(1'b1, 1'b1, l, 0, 0, 1'b0);
        default: txn(1'b0, 1'b1, ($urandom_range(0, 1) == 0) ? 16'd0
                                 : 16'($urandom_range(MAX_UDP_LEN + 1, 65535)), 0, 0, 1'b0);
      endcase
    end

    // Reset in the middle of a UDP frame, then check the next frame starts cleanly
    rdy_rand = 1'b0; src_rand = 1'b0;
    @(posedge clk); #1;
    udp_req = 1'b1; udp_len = 16'd20;
    prep_udp(16'd20, 0, 0, 1'b1, e);
    wait_ack(ga, gu);
    chk("mid_udp_ack", gu, 1'b1);
    @(posedge clk); #1 udp_req = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > 16; i++) @(negedge clk);
    #2;
    chk("mid_frame_valid", m_axis_tvalid, 1'b1);
    do_reset();
    txn(1'b1, 1'b0, 16'd0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
